sccb_request_arbiter: RTL

Shares the single SCCB write engine (`sccb_interface`) between N independent register-write requesters: the power-up ROM sequencer, runtime exposure/gain updates and a debug port. Arbitration is round-robin. The block converts each requester's level request into one engine transaction and returns a completion pulse with an error flag. A watchdog recovers the arbiter when the engine never finishes. It sits between the requesters and `sccb_interface`, in the same `clk`/`clk_en` domain.

---
 rtl/camera_pkg.sv | 20 ++
 rtl/sccb_request_arbiter_rr_pick.sv | 30 +++
 rtl/sccb_request_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared definitions for the camera control slice: SCCB field widths and
// the request-arbiter state encoding.
package camera_pkg;

    localparam int SCCB_ADDR_W = 8;
    localparam int SCCB_DATA_W = 8;

    localparam logic [1:0] STATE_IDLE      = 2'd0;
    localparam logic [1:0] STATE_ISSUE     = 2'd1;
    localparam logic [1:0] STATE_WAIT_BUSY = 2'd2;
    localparam logic [1:0] STATE_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = STATE_IDLE,
        ISSUE     = STATE_ISSUE,
        WAIT_BUSY = STATE_WAIT_BUSY,
        WAIT_DONE = STATE_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/sccb_request_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request searching
// upward from last+1, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        cand     = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % NUM_REQ);
            if (req[cand]) begin
                pick       = '0;
                pick[cand] = 1'b1;
                pick_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sccb_request_arbiter.sv
// Round-robin arbiter sharing one SCCB write engine between NUM_REQ
// requesters, with a per-transaction watchdog.
module sccb_request_arbiter
    import camera_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*SCCB_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*SCCB_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           ack_err,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           timeout_sticky,
    input  logic                           sccb_ready,
    output logic                           sccb_start,
    output logic [SCCB_ADDR_W-1:0]         sccb_addr,
    output logic [SCCB_DATA_W-1:0]         sccb_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    arb_state_t             state;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       owner;
    logic [WD_W-1:0]        wd;
    logic [WD_W-1:0]        wd_next;
    logic [NUM_REQ-1:0]     pick;
    logic [IDX_W-1:0]       pick_idx;
    logic [SCCB_ADDR_W-1:0] sel_addr;
    logic [SCCB_DATA_W-1:0] sel_data;
    logic                   in_wait;
    logic                   done_ok;
    logic                   advance;
    logic                   abort;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last     (last),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                sel_addr = req_addr[i*SCCB_ADDR_W +: SCCB_ADDR_W];
                sel_data = req_data[i*SCCB_DATA_W +: SCCB_DATA_W];
            end
        end
    end

    // Watchdog saturates at the limit; normal completion beats a same-edge timeout.
    assign wd_next = (wd == WD_LIMIT) ? wd : wd + 1'b1;
    assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign done_ok = (state == WAIT_DONE) && sccb_ready;
    assign advance = (state == WAIT_BUSY) && !sccb_ready;
    assign abort   = in_wait && !done_ok && !advance && (wd_next == WD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last           <= IDX_W'(NUM_REQ - 1);
            owner          <= '0;
            wd             <= '0;
            grant          <= '0;
            ack            <= '0;
            ack_err        <= 1'b0;
            busy           <= 1'b0;
            timeout_sticky <= 1'b0;
            sccb_start     <= 1'b0;
            sccb_addr      <= '0;
            sccb_data      <= '0;
        end else if (clk_en) begin
            ack        <= '0;
            ack_err    <= 1'b0;
            sccb_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req && sccb_ready) begin
                        grant     <= pick;
                        owner     <= pick_idx;
                        sccb_addr <= sel_addr;
                        sccb_data <= sel_data;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    sccb_start <= 1'b1;
                    wd         <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (done_ok || abort) begin
                        ack     <= grant;
                        ack_err <= abort;
                        last    <= owner;
                        grant   <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        if (abort) begin
                            timeout_sticky <= 1'b1;
                        end
                    end else begin
                        wd <= wd_next;
                        if (advance) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
